// File: rtl/sar_adc_pkg.sv
// Shared types and parameter limits for the SAR ADC controller.
// Optional averaging is enabled by defining SAR_ADC_CTRL_AVG_EN.
package sar_adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE
  } sar_state_t;

  localparam int WIDTH_MIN      = 4;
  localparam int WIDTH_MAX      = 16;
  localparam int SAMPLE_CYC_MIN = 1;
  localparam int SAMPLE_CYC_MAX = 15;
  localparam int SETTLE_MAX     = 15;
  localparam int AVG_LOG2_MAX   = 4;

  localparam int DEF_WIDTH      = 12;
  localparam int DEF_SAMPLE_CYC = 2;
  localparam int DEF_SETTLE     = 1;
  localparam int DEF_AVG_LOG2   = 2;

  // One counter serves both the sample window and the settle window.
  localparam int CNT_W = 4;

endpackage

// File: rtl/sar_adc_avg.sv
// Accumulator and conversion counter for averaged SAR requests.
// Instantiated by sar_adc_ctrl only when SAR_ADC_CTRL_AVG_EN is defined.
module sar_adc_avg
  import sar_adc_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             add,
  input  logic [WIDTH-1:0] code_in,
  output logic             req_final,
  output logic             req_done,
  output logic [WIDTH-1:0] avg_value
);

  localparam int ACC_W = WIDTH + AVG_LOG2;
  localparam int CNV_W = AVG_LOG2 + 1;
  localparam logic [CNV_W-1:0] N_CONV = CNV_W'(1 << AVG_LOG2);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNV_W-1:0] cnv;

  // The averaged value includes the code being added this cycle, so the
  // final result can be loaded on the same edge as the last conversion ends.
  assign sum       = acc + ACC_W'(code_in);
  assign avg_value = WIDTH'(sum >> AVG_LOG2);
  assign req_final = (cnv == N_CONV - CNV_W'(1));
  assign req_done  = (cnv == N_CONV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnv <= '0;
    end else if (clear) begin
      acc <= '0;
      cnv <= '0;
    end else if (add) begin
      acc <= sum;
      cnv <= cnv + CNV_W'(1);
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller with start/busy/done handshake.
// Define SAR_ADC_CTRL_AVG_EN to average 2^AVG_LOG2 conversions per request.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
  parameter int SETTLE     = DEF_SETTLE,
  parameter int AVG_LOG2   = DEF_AVG_LOG2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             cmp,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
  localparam logic [IDX_W-1:0] TOP_IDX     = IDX_W'(WIDTH - 1);
  localparam sar_state_t       BIT_ENTRY   = (SETTLE == 0) ? ST_COMPARE : ST_SETTLE;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
      SAMPLE_CYC < SAMPLE_CYC_MIN || SAMPLE_CYC > SAMPLE_CYC_MAX ||
      SETTLE < 0 || SETTLE > SETTLE_MAX ||
      AVG_LOG2 < 0 || AVG_LOG2 > AVG_LOG2_MAX) begin : g_param_err
    $error("sar_adc_ctrl: parameter out of range");
  end

  sar_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] code;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] trial_bit, code_kept, code_after;
  logic             conv_last;
  logic             result_load;
  logic [WIDTH-1:0] conv_result;

  // Resolve the current trial bit and stage the next one in the same edge.
  always_comb begin
    trial_bit  = ONE << bit_idx;
    code_kept  = cmp ? code : (code & ~trial_bit);
    code_after = (bit_idx != '0) ? (code_kept | (trial_bit >> 1)) : code_kept;
  end

`ifdef SAR_ADC_CTRL_AVG_EN
  logic             avg_clear, avg_add, req_final, req_done;
  logic [WIDTH-1:0] avg_value;

  // Clear only at the start of a whole request, not between its conversions.
  assign avg_clear = (state_next == ST_SAMPLE) &&
                     ((state == ST_IDLE) || ((state == ST_DONE) && req_done));
  assign avg_add   = (state == ST_COMPARE) && (bit_idx == '0);

  sar_adc_avg #(
    .WIDTH    (WIDTH),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (avg_clear),
    .add       (avg_add),
    .code_in   (code_kept),
    .req_final (req_final),
    .req_done  (req_done),
    .avg_value (avg_value)
  );

  assign conv_last   = req_done;
  assign conv_result = avg_value;
  assign result_load = avg_add && req_final;
`else
  assign conv_last   = 1'b1;
  assign conv_result = code_kept;
  assign result_load = (state == ST_COMPARE) && (bit_idx == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_SAMPLE;
      ST_SAMPLE:  if (cnt == SAMPLE_LAST) state_next = BIT_ENTRY;
      ST_SETTLE:  if (cnt == SETTLE_LAST) state_next = ST_COMPARE;
      ST_COMPARE: state_next = (bit_idx == '0) ? ST_DONE : BIT_ENTRY;
      ST_DONE: begin
        if (!conv_last || start || cont) state_next = ST_SAMPLE;
        else                             state_next = ST_IDLE;
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sample   = (state == ST_SAMPLE);
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE) && conv_last;
    dac_code = code;
    result   = result_q;
  end

  // The code register is zero outside a conversion and holds the final
  // code through DONE; the counter only runs while waiting in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      bit_idx  <= '0;
      code     <= '0;
      result_q <= '0;
    end else begin
      cnt <= ((state_next == state) && (state == ST_SAMPLE || state == ST_SETTLE))
             ? cnt + CNT_W'(1) : '0;
      if (result_load) result_q <= conv_result;
      case (state)
        ST_SAMPLE: begin
          if (state_next != ST_SAMPLE) begin
            code    <= ONE << TOP_IDX;
            bit_idx <= TOP_IDX;
          end
        end
        ST_COMPARE: begin
          code <= code_after;
          if (bit_idx != '0) bit_idx <= bit_idx - IDX_W'(1);
        end
        ST_DONE:  code <= '0;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed self-checking bench for sar_adc_ctrl with a comparator model.
// Averaging checks are included when SAR_ADC_CTRL_AVG_EN is defined.
module tb_sar_adc_ctrl;

`ifdef SAR_ADC_CTRL_AVG_EN
  localparam int AVG_N = 4;
`else
  localparam int AVG_N = 1;
`endif
  localparam int PERIOD  = AVG_N * 27;
  localparam int PERIOD8 = AVG_N * 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, cont = 1'b0, cmp;
  logic        sample, busy, done;
  logic [11:0] dac_code, result, vin = '0;

  logic        start8 = 1'b0, cont8 = 1'b0, cmp8;
  logic        sample8, busy8, done8;
  logic [7:0]  dac8, result8, vin8 = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign cmp  = (vin >= dac_code);
  assign cmp8 = (vin8 >= dac8);

  sar_adc_ctrl dut (
    .clk (clk), .rst_n (rst_n), .start (start), .cont (cont), .cmp (cmp),
    .sample (sample), .dac_code (dac_code), .busy (busy), .result (result), .done (done)
  );

  sar_adc_ctrl #(.WIDTH (8), .SAMPLE_CYC (2), .SETTLE (0), .AVG_LOG2 (2)) dut8 (
    .clk (clk), .rst_n (rst_n), .start (start8), .cont (cont8), .cmp (cmp8),
    .sample (sample8), .dac_code (dac8), .busy (busy8), .result (result8), .done (done8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a posedge with the DUT idle; the next posedge is e0.
  task automatic applyStimulus(input logic [11:0] v, output int done_edge, output int done_cnt,
                               output logic [11:0] res, output logic busy_after,
                               output logic [3:0][11:0] trace);
    vin = v; done_edge = -1; done_cnt = 0; res = '0; busy_after = 1'b1; trace = '0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= PERIOD + 3; n++) begin
      @(posedge clk); #1;
      if (n >= 2 && n <= 8 && (n % 2) == 0) trace[n/2-1] = dac_code;
      if (done) begin
        done_cnt++;
        if (done_edge < 0) begin done_edge = n; res = result; end
      end
      if (n == PERIOD) busy_after = busy;
    end
  endtask

  int               de, dc, dn;
  logic [11:0]      res;
  logic             ba, bz;
  logic [3:0][11:0] tr;
  logic [31:0]      seen;
  int               cont_edges [3];
  logic [11:0]      cont_res [3];
  logic [7:0]       d8_e2, d8_e3;

  initial begin
    #12;
    checkOutput("reset_outputs", {5'b0, sample, dac_code, busy, result, done}, 32'h0);
    rst_n = 1'b1;
    seen = '0;
    repeat (100) begin
      @(posedge clk); #1;
      seen = seen | {5'b0, sample, dac_code, busy, result, done}
                  | {12'b0, sample8, dac8, busy8, result8, done8};
    end
    checkOutput("idle_quiet", seen, 32'h0);

    applyStimulus(12'hA5C, de, dc, res, ba, tr);
    checkOutput("a5c_trial_e2", tr[0], 12'h800);
    checkOutput("a5c_trial_e4", tr[1], 12'hC00);
    checkOutput("a5c_trial_e6", tr[2], 12'hA00);
    checkOutput("a5c_trial_e8", tr[3], 12'hB00);
    checkOutput("a5c_done_edge", de, PERIOD - 1);
    checkOutput("a5c_done_count", dc, 1);
    checkOutput("a5c_result", res, 12'hA5C);
    checkOutput("a5c_busy_after", ba, 1'b0);

    applyStimulus(12'h000, de, dc, res, ba, tr);
    checkOutput("zero_result", res, 12'h000);
    checkOutput("zero_done_edge", de, PERIOD - 1);
    applyStimulus(12'hFFF, de, dc, res, ba, tr);
    checkOutput("full_result", res, 12'hFFF);
    checkOutput("full_done_edge", de, PERIOD - 1);

    // Narrow instance, no settle cycles.
    vin8 = 8'h5A; de = -1; res = '0; d8_e2 = '0; d8_e3 = '0;
    start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    for (int n = 1; n <= PERIOD8 + 3; n++) begin
      @(posedge clk); #1;
      if (n == 2) d8_e2 = dac8;
      if (n == 3) d8_e3 = dac8;
      if (done8 && de < 0) begin de = n; res = {4'b0, result8}; end
    end
    checkOutput("w8_trial_e2", d8_e2, 8'h80);
    checkOutput("w8_trial_e3", d8_e3, 8'h40);
    checkOutput("w8_done_edge", de, PERIOD8 - 1);
    checkOutput("w8_result", res, 12'h05A);

    // Continuous mode with ignored start pulses mid-conversion.
    vin = 12'h123; cont = 1'b1; dc = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 3 * PERIOD + 5; n++) begin
      @(posedge clk); #1;
      if (dc > 0 && n == cont_edges[dc-1] + 1) checkOutput($sformatf("cont_sample_%0d", dc), sample, 1'b1);
      start = (n == PERIOD + 13) || (n == 2 * PERIOD + 11);
      if (done && dc < 3) begin cont_edges[dc] = n; cont_res[dc] = result; dc++; end
    end
    checkOutput("cont_done_count", dc, 3);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("cont_edge_%0d", k), cont_edges[k], (k + 1) * PERIOD - 1);
      checkOutput($sformatf("cont_result_%0d", k), cont_res[k], 12'h123);
    end
    cont = 1'b0; dn = -1; bz = 1'b1;
    for (int n = 0; n < PERIOD + 5; n++) begin
      @(posedge clk); #1;
      if (dn >= 0 && n == dn + 1) bz = busy;
      if (done && dn < 0) dn = n;
    end
    checkOutput("cont_stop_done", dn >= 0, 1'b1);
    checkOutput("cont_stop_idle", bz, 1'b0);

    // Asynchronous reset in the middle of a conversion.
    vin = 12'h3C7;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    checkOutput("midrst_outputs", {5'b0, sample, dac_code, busy, result, done}, 32'h0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_idle", busy, 1'b0);
    applyStimulus(12'h3C7, de, dc, res, ba, tr);
    checkOutput("midrst_done_edge", de, PERIOD - 1);
    checkOutput("midrst_result", res, 12'h3C7);

`ifdef SAR_ADC_CTRL_AVG_EN
    // Input steps by one code per conversion; average truncates to 0x101.
    vin = 12'h100; dc = 0; de = -1; res = '0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= PERIOD + 5; n++) begin
      @(posedge clk); #1;
      if (n < PERIOD) vin = 12'h100 + 12'(n / 27);
      if (done) begin
        dc++;
        if (de < 0) begin de = n; res = result; end
      end
    end
    checkOutput("avg_done_count", dc, 1);
    checkOutput("avg_done_edge", de, 107);
    checkOutput("avg_result", res, 12'h101);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
